// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// The misalignment helper is only used when LSU_MISALIGN_TRAP_EN is defined.
package load_store_unit_pkg;

   localparam int SRAM_MEMORY_SIZE  = 2048;
   localparam int SRAM_READ_LATENCY = 2;
   localparam int SRAM_ADDR_WIDTH   = $clog2(SRAM_MEMORY_SIZE);

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } funct3_load_t;

   typedef enum logic [2:0] {
      F3_SB = 3'b000,
      F3_SH = 3'b001,
      F3_SW = 3'b010
   } funct3_store_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD1  = 3'd1,
      RD2  = 3'd2,
      RMW1 = 3'd3,
      RMW2 = 3'd4,
      RESP = 3'd5,
      ERR  = 3'd6
   } lsu_state_t;

   localparam logic [1:0] LSU_HALF_MASK = 2'b01;
   localparam logic [1:0] LSU_WORD_MASK = 2'b11;

   // funct3[1:0] encodes the access size for both loads and stores
   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (funct3[1:0] == 2'b01)
         mis = (addr_lo & LSU_HALF_MASK) != 2'b00;
      else if (funct3[1:0] == 2'b10)
         mis = (addr_lo & LSU_WORD_MASK) != 2'b00;
      return mis;
   endfunction

   function automatic logic lsu_load_legal(input logic [2:0] funct3);
      return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
             (funct3 == F3_LBU) || (funct3 == F3_LHU);
   endfunction

   function automatic logic lsu_store_legal(input logic [2:0] funct3);
      return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
   endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: little-endian extract/extend for loads and
// lane merge of store data into a read-back word for read-modify-write.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic [1:0] addr_lo_i,
   input  word_t      rdata_i,
   input  word_t      wdata_i,
   output word_t      load_data_o,
   output word_t      store_data_o
);

   logic [7:0]  byteVal;
   logic [15:0] halfVal;
   logic        signExt;

   // Halfword lane is picked by addr[1] alone, so addr[0] is ignored for halves
   always_comb begin
      byteVal      = rdata_i[{addr_lo_i, 3'b000} +: 8];
      halfVal      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      signExt      = ~funct3_i[2];
      load_data_o  = rdata_i;
      store_data_o = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            load_data_o  = {{24{signExt & byteVal[7]}}, byteVal};
            store_data_o = rdata_i;
            store_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         2'b01: begin
            load_data_o  = {{16{signExt & halfVal[15]}}, halfVal};
            store_data_o = rdata_i;
            if (addr_lo_i[1])
               store_data_o[31:16] = wdata_i[15:0];
            else
               store_data_o[15:0] = wdata_i[15:0];
         end
         default: begin
            load_data_o  = rdata_i;
            store_data_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and a 2-cycle single-port SRAM.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into errors.
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [2:0]                 req_funct3,
   input  logic [31:0]                req_addr,
   input  logic [31:0]                req_wdata,
   output logic                       resp_valid,
   output logic [31:0]                resp_rdata,
   output logic                       resp_err,
   output logic                       sram_en,
   output logic                       sram_we,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]                sram_din,
   input  logic [31:0]                sram_dout
);

   lsu_state_t                 state_q, state_d;
   logic [2:0]                 funct3_q;
   logic [1:0]                 addrLo_q;
   word_t                      wdata_q;
   word_t                      rdata_q;
   logic [SRAM_ADDR_WIDTH-1:0] waddr_q;
   logic                       accept;
   logic                       reqErr;
   logic                       misalign;
   logic                       funct3Bad;
   word_t                      loadData;
   word_t                      storeData;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;

   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = lsu_misaligned(req_funct3, req_addr[1:0]);
`else
      misalign = 1'b0;
`endif
      funct3Bad = req_we ? !lsu_store_legal(req_funct3) : !lsu_load_legal(req_funct3);
      reqErr    = funct3Bad || misalign || (req_addr[31:SRAM_ADDR_WIDTH+2] != '0);
   end

   lsu_align uAlign (
      .funct3_i     (funct3_q),
      .addr_lo_i    (addrLo_q),
      .rdata_i      (sram_dout),
      .wdata_i      (wdata_q),
      .load_data_o  (loadData),
      .store_data_o (storeData)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (reqErr)
                  state_d = ERR;
               else if (!req_we)
                  state_d = RD1;
               else if (req_funct3 == F3_SW)
                  state_d = RESP;
               else
                  state_d = RMW1;
            end
         end
         RD1:     state_d = RD2;
         RD2:     state_d = RESP;
         RMW1:    state_d = RMW2;
         RMW2:    state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         funct3_q <= '0;
         addrLo_q <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         waddr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            funct3_q <= req_funct3;
            addrLo_q <= req_addr[1:0];
            wdata_q  <= req_wdata;
            waddr_q  <= req_addr[SRAM_ADDR_WIDTH+1:2];
            rdata_q  <= '0;
         end else if (state_q == RD2) begin
            rdata_q <= loadData;
         end
      end
   end

   // SRAM strobes are gated by rst so an in-flight access drops the instant reset rises
   always_comb begin
      sram_en   = 1'b0;
      sram_we   = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      if (!rst) begin
         if (state_q == IDLE && accept && !reqErr) begin
            sram_en   = 1'b1;
            sram_we   = req_we && (req_funct3 == F3_SW);
            sram_addr = req_addr[SRAM_ADDR_WIDTH+1:2];
            sram_din  = sram_we ? req_wdata : '0;
         end else if (state_q == RMW2) begin
            sram_en   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = waddr_q;
            sram_din  = storeData;
         end
      end
   end

   assign resp_valid = (state_q == RESP) || (state_q == ERR);
   assign resp_err   = (state_q == ERR);
   assign resp_rdata = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 2-cycle-latency SRAM model;
// responses are matched against queued expectations including arrival cycle.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic                       clk;
   logic                       rst;
   logic                       req_valid;
   logic                       req_ready;
   logic                       req_we;
   logic [2:0]                 req_funct3;
   logic [31:0]                req_addr;
   logic [31:0]                req_wdata;
   logic                       resp_valid;
   logic [31:0]                resp_rdata;
   logic                       resp_err;
   logic                       sram_en;
   logic                       sram_we;
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
   logic [31:0]                sram_din;
   logic [31:0]                sram_dout;

   logic [31:0] mem [0:SRAM_MEMORY_SIZE-1];
   logic [31:0] rdStage;
   exp_t        expQ[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   int          wrCnt      = 0;
   int          enCnt      = 0;
   int          respCnt    = 0;
   logic [31:0] lastDin    = '0;
   logic [31:0] lastWaddr  = '0;

   load_store_unit dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: read data appears two edges after the enable cycle
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sram_en && sram_we)
         mem[sram_addr] <= sram_din;
      rdStage   <= mem[sram_addr];
      sram_dout <= rdStage;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Activity counters and scoreboard monitor
   always @(negedge clk) begin
      if (sram_en)
         enCnt++;
      if (sram_en && sram_we) begin
         wrCnt++;
         lastDin   = sram_din;
         lastWaddr = 32'(sram_addr);
      end
      if (resp_valid) begin
         respCnt++;
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_resp: got resp at cycle %0d, expected none", cyc);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("resp_rdata", resp_rdata, e.rdata);
            checkOutput("resp_err", 32'(resp_err), 32'(e.err));
            checkOutput("resp_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic expErr,
                                input logic [31:0] expRdata, input int lat);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ready_wait", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      e.rdata = expRdata;
      e.err   = expErr;
      e.cyc   = cyc + lat;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int wrBase;
      int enBase;
      int respBase;
      logic [31:0] misExpData;
      logic        misExpErr;

      for (int i = 0; i < SRAM_MEMORY_SIZE; i++)
         mem[i] = '0;
      mem[5]     = 32'h80FF7F01;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;

      repeat (2) @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
      checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
      checkOutput("rst_sram_en", 32'(sram_en), 32'd0);
      checkOutput("rst_sram_we", 32'(sram_we), 32'd0);
      checkOutput("rst_sram_addr", 32'(sram_addr), 32'd0);
      checkOutput("rst_sram_din", sram_din, 32'd0);
      rst = 1'b0;

      // Byte/half extraction from word 5 = 0x80FF7F01
      applyStimulus(1'b0, 3'b000, 32'h15, '0, 1'b0, 32'h0000007F, 3);
      applyStimulus(1'b0, 3'b000, 32'h17, '0, 1'b0, 32'hFFFFFF80, 3);
      applyStimulus(1'b0, 3'b100, 32'h17, '0, 1'b0, 32'h00000080, 3);
      applyStimulus(1'b0, 3'b001, 32'h16, '0, 1'b0, 32'hFFFF80FF, 3);
      applyStimulus(1'b0, 3'b101, 32'h16, '0, 1'b0, 32'h000080FF, 3);
      applyStimulus(1'b0, 3'b010, 32'h14, '0, 1'b0, 32'h80FF7F01, 3);

      applyStimulus(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1'b0, 32'h0, 1);
      applyStimulus(1'b0, 3'b010, 32'h20, '0, 1'b0, 32'hDEADBEEF, 3);
      waitDrain();

      wrBase = wrCnt;
      applyStimulus(1'b1, 3'b001, 32'h22, 32'h00001234, 1'b0, 32'h0, 3);
      waitDrain();
      checkOutput("sh_write_count", 32'(wrCnt - wrBase), 32'd1);
      checkOutput("sh_write_din", lastDin, 32'h1234BEEF);
      checkOutput("sh_write_addr", lastWaddr, 32'd8);
      applyStimulus(1'b0, 3'b101, 32'h22, '0, 1'b0, 32'h00001234, 3);

      applyStimulus(1'b1, 3'b000, 32'h21, 32'hFFFFFF55, 1'b0, 32'h0, 3);
      applyStimulus(1'b0, 3'b010, 32'h20, '0, 1'b0, 32'h123455EF, 3);
      applyStimulus(1'b0, 3'b000, 32'h20, '0, 1'b0, 32'hFFFFFFEF, 3);
      waitDrain();

`ifdef LSU_MISALIGN_TRAP_EN
      misExpErr  = 1'b1;
      misExpData = 32'h0;
`else
      misExpErr  = 1'b0;
      misExpData = 32'h123455EF;
`endif
      enBase = enCnt;
      applyStimulus(1'b0, 3'b010, 32'h21, '0, misExpErr, misExpData, misExpErr ? 1 : 3);
      waitDrain();
      checkOutput("misalign_en_count", 32'(enCnt - enBase), misExpErr ? 32'd0 : 32'd1);

      enBase = enCnt;
      applyStimulus(1'b0, 3'b011, 32'h20, '0, 1'b1, 32'h0, 1);
      applyStimulus(1'b0, 3'b010, 32'h00002000, '0, 1'b1, 32'h0, 1);
      applyStimulus(1'b1, 3'b011, 32'h20, 32'h1, 1'b1, 32'h0, 1);
      waitDrain();
      checkOutput("err_en_count", 32'(enCnt - enBase), 32'd0);

      // Reset during RMW1 of an SB must abandon the write and the response
      wrBase   = wrCnt;
      respBase = respCnt;
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h14;
      req_wdata  = 32'h000000AA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_release_ready", 32'(req_ready), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("rst_rmw_writes", 32'(wrCnt - wrBase), 32'd0);
      checkOutput("rst_rmw_resps", 32'(respCnt - respBase), 32'd0);
      checkOutput("rst_rmw_mem5", mem[5], 32'h80FF7F01);
      applyStimulus(1'b0, 3'b010, 32'h14, '0, 1'b0, 32'h80FF7F01, 3);
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
